// File: rtl/reg_bank16_16.sv
// reg_bank16_16: 16 x 16-bit register bank with one write/modify port.
// Supports plain write, wrap-around add and a sequenced clear-all that
// zeroes one entry per cycle. busy/ack/err give handshake feedback, and
// every entry is exposed as a direct register output (mem0..mem15).
module reg_bank16_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ack,
  output logic             err,
  output logic [WIDTH-1:0] mem0,
  output logic [WIDTH-1:0] mem1,
  output logic [WIDTH-1:0] mem2,
  output logic [WIDTH-1:0] mem3,
  output logic [WIDTH-1:0] mem4,
  output logic [WIDTH-1:0] mem5,
  output logic [WIDTH-1:0] mem6,
  output logic [WIDTH-1:0] mem7,
  output logic [WIDTH-1:0] mem8,
  output logic [WIDTH-1:0] mem9,
  output logic [WIDTH-1:0] mem10,
  output logic [WIDTH-1:0] mem11,
  output logic [WIDTH-1:0] mem12,
  output logic [WIDTH-1:0] mem13,
  output logic [WIDTH-1:0] mem14,
  output logic [WIDTH-1:0] mem15
);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state logic: decode the op in IDLE, walk the clear counter in CLEAR.
  // On the final clear cycle the completion ack takes priority over a
  // rejection err so that the two pulses never coincide.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        case (op)
          OP_WRITE: begin
            mem_d[addr] = wdata;
            ack_d       = 1'b1;
          end
          OP_ADD: begin
            mem_d[addr] = mem_q[addr] + wdata;
            ack_d       = 1'b1;
          end
          OP_CLEAR: begin
            state_d = CLEAR;
            cnt_d   = 4'd0;
          end
          default: begin
          end
        endcase
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        if (op != OP_NOP) begin
          err_d = 1'b1;
        end
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          ack_d   = 1'b1;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, handshake and entry registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign busy  = (state_q == CLEAR);
  assign ack   = ack_q;
  assign err   = err_q;
  assign mem0  = mem_q[0];
  assign mem1  = mem_q[1];
  assign mem2  = mem_q[2];
  assign mem3  = mem_q[3];
  assign mem4  = mem_q[4];
  assign mem5  = mem_q[5];
  assign mem6  = mem_q[6];
  assign mem7  = mem_q[7];
  assign mem8  = mem_q[8];
  assign mem9  = mem_q[9];
  assign mem10 = mem_q[10];
  assign mem11 = mem_q[11];
  assign mem12 = mem_q[12];
  assign mem13 = mem_q[13];
  assign mem14 = mem_q[14];
  assign mem15 = mem_q[15];

endmodule
